// File: rtl/mem_access_ctrl_if.sv
// Memory-side handshake bundle for mem_access_ctrl: single-outstanding req/ack bus.
// The controller drives it through the master modport and the memory through slave.
interface mem_access_ctrl_if #(
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned DATA_W = 16
);
    logic              o_MemReq;
    logic              o_MemWe;
    logic [ADDR_W-1:0] o_MemAddr;
    logic [DATA_W-1:0] o_MemWData;
    logic [DATA_W-1:0] i_MemRData;
    logic              i_MemAck;

    modport master (
        output o_MemReq, o_MemWe, o_MemAddr, o_MemWData,
        input  i_MemRData, i_MemAck
    );

    modport slave (
        input  o_MemReq, o_MemWe, o_MemAddr, o_MemWData,
        output i_MemRData, i_MemAck
    );
endinterface

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: MAR/MDR holder and single-outstanding memory access sequencer.
// Returns the ready pulse o_R to the microsequencer when an access finishes.
// Optional feature: define MEM_ACV_EN to reject user-mode accesses outside
// 16'h3000..16'hFDFF without issuing a memory request (o_ACV pulses with o_R).
module mem_access_ctrl #(
    parameter int unsigned ADDR_W   = 16,
    parameter int unsigned DATA_W   = 16,
    parameter int unsigned MAX_WAIT = 255
) (
    input  logic              i_Clk,
    input  logic              i_Rst_n,
    input  logic [DATA_W-1:0] i_Bus,
    input  logic              i_LdMAR,
    input  logic              i_LdMDR,
    input  logic              i_MIO_EN,
    input  logic              i_R_W,
    input  logic              i_PSR15,
    output logic [ADDR_W-1:0] o_MAR,
    output logic [DATA_W-1:0] o_MDR,
    output logic              o_R,
    output logic              o_BusErr,
    output logic              o_ACV,
    mem_access_ctrl_if.master mem
);

    localparam int unsigned CNT_W = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] mar_q, mar_d;
    logic [DATA_W-1:0] mdr_q, mdr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              we_q, we_d;
    logic              req_q, req_d;
    logic              r_q, r_d;
    logic              buserr_q, buserr_d;
    logic              acv_q, acv_d;

`ifdef MEM_ACV_EN
    logic acv_hit_c;
`else
    logic unused_psr15;
    assign unused_psr15 = i_PSR15;
`endif

    // State and datapath registers; async reset abandons any in-flight access.
    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            state_q  <= S_IDLE;
            mar_q    <= '0;
            mdr_q    <= '0;
            cnt_q    <= '0;
            we_q     <= 1'b0;
            req_q    <= 1'b0;
            r_q      <= 1'b0;
            buserr_q <= 1'b0;
            acv_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            mar_q    <= mar_d;
            mdr_q    <= mdr_d;
            cnt_q    <= cnt_d;
            we_q     <= we_d;
            req_q    <= req_d;
            r_q      <= r_d;
            buserr_q <= buserr_d;
            acv_q    <= acv_d;
        end
    end

    // Next-state and next-output logic; outputs are the registered copies of *_d.
    always_comb begin
        state_d  = state_q;
        mar_d    = mar_q;
        mdr_d    = mdr_q;
        cnt_d    = cnt_q;
        we_d     = we_q;
        req_d    = 1'b0;
        r_d      = 1'b0;
        buserr_d = 1'b0;
        acv_d    = 1'b0;
`ifdef MEM_ACV_EN
        acv_hit_c = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                if (i_LdMAR) begin
                    mar_d = i_Bus[ADDR_W-1:0];
                end
                // An access start takes priority over a bus load of MDR.
                if (i_LdMDR && !i_MIO_EN) begin
                    mdr_d = i_Bus;
                end
                if (i_MIO_EN) begin
                    cnt_d = '0;
`ifdef MEM_ACV_EN
                    acv_hit_c = i_PSR15 &&
                                ((mar_d < ADDR_W'(16'h3000)) || (mar_d >= ADDR_W'(16'hFE00)));
                    if (acv_hit_c) begin
                        we_d    = 1'b0;
                        state_d = S_DONE;
                        r_d     = 1'b1;
                        acv_d   = 1'b1;
                    end else begin
                        we_d    = i_R_W;
                        state_d = S_REQ;
                        req_d   = 1'b1;
                    end
`else
                    we_d    = i_R_W;
                    state_d = S_REQ;
                    req_d   = 1'b1;
`endif
                end
            end
            S_REQ: begin
                cnt_d = cnt_q + CNT_W'(1);
                // Ack is checked first so an ack on the timeout cycle still completes normally.
                if (mem.i_MemAck) begin
                    if (!we_q) begin
                        mdr_d = mem.i_MemRData;
                    end
                    we_d    = 1'b0;
                    state_d = S_DONE;
                    r_d     = 1'b1;
                end else if ((MAX_WAIT != 0) && (cnt_q == CNT_W'(MAX_WAIT - 1))) begin
                    we_d     = 1'b0;
                    state_d  = S_DONE;
                    r_d      = 1'b1;
                    buserr_d = 1'b1;
                end else begin
                    req_d = 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                we_d    = 1'b0;
            end
        endcase
    end

    assign o_MAR          = mar_q;
    assign o_MDR          = mdr_q;
    assign o_R            = r_q;
    assign o_BusErr       = buserr_q;
    assign o_ACV          = acv_q;
    assign mem.o_MemReq   = req_q;
    assign mem.o_MemWe    = we_q;
    assign mem.o_MemAddr  = mar_q;
    assign mem.o_MemWData = mdr_q;

endmodule
